// File: rtl/fmul_pkg.sv
// Shared definitions for the single-precision multiplier post-normalisation stage.
// Holds the operand class encoding, IEEE-754 binary32 field constants and the
// bit positions of the {overflow, underflow, inexact} flag vector.
package fmul_pkg;

    // Operand class carried alongside the raw significand product.
    typedef enum logic [1:0] {
        ClsNormal = 2'b00,
        ClsZero   = 2'b01,
        ClsInf    = 2'b10,
        ClsNan    = 2'b11
    } fmul_class_e;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int FRAC_W  = 23;

    // Positions within the 3-bit flags vector.
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_NX  = 0;

endpackage

// File: rtl/fmul_post_norm_if.sv
// Product-in / result-out bus of the multiplier post-normalisation stage.
//   s_valid/s_ready     : product handshake (upstream -> stage)
//   s_sign, s_exp       : product sign and signed biased exponent sum (EXP_W bits)
//   s_mant              : raw 24x24 significand product
//   s_class             : operand class (normal, zero, inf, NaN)
//   m_valid/m_ready     : result handshake (stage -> downstream)
//   z, flags            : binary32 result and {overflow, underflow, inexact}
// Modports: master = environment driving products and sinking results,
//           slave  = the post-normalisation stage itself.
interface fmul_post_norm_if #(
    parameter int EXP_W = 10
) ();
    import fmul_pkg::*;

    logic                    s_valid;
    logic                    s_ready;
    logic                    s_sign;
    logic signed [EXP_W-1:0] s_exp;
    logic [47:0]             s_mant;
    fmul_class_e             s_class;
    logic                    m_valid;
    logic                    m_ready;
    logic [31:0]             z;
    logic [2:0]              flags;

    modport master (
        output s_valid,
        output s_sign,
        output s_exp,
        output s_mant,
        output s_class,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  z,
        input  flags
    );

    modport slave (
        input  s_valid,
        input  s_sign,
        input  s_exp,
        input  s_mant,
        input  s_class,
        input  m_ready,
        output s_ready,
        output m_valid,
        output z,
        output flags
    );

endinterface

// File: rtl/fmul_round.sv
// Combinational round-to-nearest-even of a 23-bit fraction.
//   i_frac   : fraction before rounding
//   i_guard  : first bit below the fraction
//   i_sticky : OR of every bit below the guard
//   i_lsb    : fraction LSB (tie-break bit)
//   o_frac   : rounded fraction
//   o_carry  : rounding carried out of the fraction (caller bumps the exponent)
module fmul_round
    import fmul_pkg::*;
(
    input  logic [FRAC_W-1:0] i_frac,
    input  logic              i_guard,
    input  logic              i_sticky,
    input  logic              i_lsb,
    output logic [FRAC_W-1:0] o_frac,
    output logic              o_carry
);

    logic w_round_up;

    // Exact ties round toward the even fraction.
    assign w_round_up = i_guard & (i_sticky | i_lsb);

    assign {o_carry, o_frac} = {1'b0, i_frac} + {{FRAC_W{1'b0}}, w_round_up};

endmodule

// File: rtl/fmul_post_norm.sv
// Post-normalisation, rounding and packing of a single-precision multiply.
// Two-stage pipeline: stage 1 normalises the raw 48-bit significand product,
// stage 2 rounds (nearest-even), handles exponent over/underflow and special
// classes and holds the packed result until the consumer takes it.
// A result presented on the bus in cycle t is visible on m_valid/z/flags in
// cycle t+2 when not stalled; one result per cycle sustained.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset, clears all valids and the outputs
//   bus  : fmul_post_norm_if.slave (product in, result out)
// Parameters:
//   EXP_W     : width of the signed biased exponent sum
//   NAN_CANON : quiet NaN emitted for every NaN result
// Build option:
//   FMUL_DENORM_EN : defined -> tiny results become subnormals with correct
//                    rounding; undefined -> tiny results flush to signed zero.
module fmul_post_norm
    import fmul_pkg::*;
#(
    parameter int          EXP_W     = 10,
    parameter logic [31:0] NAN_CANON = 32'h7FC0_0000
) (
    input  logic            clk,
    input  logic            rst,
    fmul_post_norm_if.slave bus
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_st1_v;
    logic r_st2_v;
    logic w_st1_en;
    logic w_st2_en;

    assign w_st2_en = !r_st2_v || bus.m_ready;
    assign w_st1_en = !r_st1_v || w_st2_en;

    assign bus.s_ready = w_st1_en;

    // ------------------------------------------------------------------
    // Stage 1: normalise
    // ------------------------------------------------------------------
    logic [FRAC_W-1:0]   w_n_frac;
    logic                w_n_guard;
    logic                w_n_sticky;
    logic signed [EXP_W:0] w_n_exp;

    always_comb begin
        // The product of two 1.x significands is in [1,4): leading one is bit 47 or 46.
        if (bus.s_mant[47]) begin
            w_n_frac   = bus.s_mant[46:24];
            w_n_guard  = bus.s_mant[23];
            w_n_sticky = |bus.s_mant[22:0];
        end else begin
            w_n_frac   = bus.s_mant[45:23];
            w_n_guard  = bus.s_mant[22];
            w_n_sticky = |bus.s_mant[21:0];
        end
        w_n_exp = $signed({bus.s_exp[EXP_W-1], bus.s_exp})
                + $signed({{EXP_W{1'b0}}, bus.s_mant[47]});
    end

    logic                  r_st1_sign;
    logic signed [EXP_W:0] r_st1_exp;
    logic [FRAC_W-1:0]     r_st1_frac;
    logic                  r_st1_guard;
    logic                  r_st1_sticky;
    fmul_class_e           r_st1_class;

    // ------------------------------------------------------------------
    // Stage 2: round and pack
    // ------------------------------------------------------------------
    logic                    w_tiny;
    logic [FRAC_W-1:0]       w_r_frac_in;
    logic                    w_r_guard;
    logic                    w_r_sticky;
    logic signed [EXP_W+1:0] w_exp_base;
    logic signed [EXP_W+1:0] w_exp_fin;
    logic [FRAC_W-1:0]       w_rnd_frac;
    logic                    w_rnd_carry;
    logic                    w_inexact;
    logic [31:0]             w_z;
    logic [2:0]              w_flags;

    assign w_tiny = (int'(r_st1_exp) <= 0);

`ifdef FMUL_DENORM_EN
    logic [4:0]  w_sh;
    logic [48:0] w_den;

    always_comb begin
        // Shift by 1-exp; beyond 25 every significand bit already lands in sticky.
        if (!w_tiny) begin
            w_sh = '0;
        end else if (int'(r_st1_exp) < -24) begin
            w_sh = 5'd25;
        end else begin
            w_sh = 5'(1 - int'(r_st1_exp));
        end
        // {hidden 1, frac, guard} followed by room for the bits shifted out.
        w_den = 49'({1'b1, r_st1_frac, r_st1_guard, 25'b0} >> w_sh);

        if (w_tiny) begin
            w_r_frac_in = w_den[48:26];
            w_r_guard   = w_den[25];
            w_r_sticky  = (|w_den[24:0]) | r_st1_sticky;
            w_exp_base  = '0;
        end else begin
            w_r_frac_in = r_st1_frac;
            w_r_guard   = r_st1_guard;
            w_r_sticky  = r_st1_sticky;
            w_exp_base  = {r_st1_exp[EXP_W], r_st1_exp};
        end
    end
`else
    always_comb begin
        w_r_frac_in = r_st1_frac;
        w_r_guard   = r_st1_guard;
        w_r_sticky  = r_st1_sticky;
        w_exp_base  = {r_st1_exp[EXP_W], r_st1_exp};
    end
`endif

    fmul_round u_round (
        .i_frac   (w_r_frac_in),
        .i_guard  (w_r_guard),
        .i_sticky (w_r_sticky),
        .i_lsb    (w_r_frac_in[0]),
        .o_frac   (w_rnd_frac),
        .o_carry  (w_rnd_carry)
    );

    // A carry out of a subnormal fraction naturally promotes it to exponent 1.
    assign w_exp_fin = w_exp_base + $signed({{(EXP_W+1){1'b0}}, w_rnd_carry});
    assign w_inexact = w_r_guard | w_r_sticky;

    always_comb begin
        w_z     = '0;
        w_flags = '0;
        unique case (r_st1_class)
            ClsZero: w_z = {r_st1_sign, 31'b0};
            ClsInf:  w_z = {r_st1_sign, 8'hFF, 23'b0};
            ClsNan:  w_z = NAN_CANON;
            default: begin
                if (int'(w_exp_fin) >= EXP_MAX) begin
                    w_z               = {r_st1_sign, 8'hFF, 23'b0};
                    w_flags[FLAG_OVF] = 1'b1;
                    w_flags[FLAG_NX]  = 1'b1;
`ifndef FMUL_DENORM_EN
                end else if (w_tiny) begin
                    w_z               = {r_st1_sign, 31'b0};
                    w_flags[FLAG_UNF] = 1'b1;
                    w_flags[FLAG_NX]  = 1'b1;
`endif
                end else begin
                    w_z              = {r_st1_sign, w_exp_fin[7:0], w_rnd_frac};
                    w_flags[FLAG_NX] = w_inexact;
`ifdef FMUL_DENORM_EN
                    w_flags[FLAG_UNF] = w_tiny & w_inexact;
`endif
                end
            end
        endcase
    end

    logic [31:0] r_z;
    logic [2:0]  r_flags;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st1_v      <= 1'b0;
            r_st1_sign   <= 1'b0;
            r_st1_exp    <= '0;
            r_st1_frac   <= '0;
            r_st1_guard  <= 1'b0;
            r_st1_sticky <= 1'b0;
            r_st1_class  <= ClsNormal;
            r_st2_v      <= 1'b0;
            r_z          <= '0;
            r_flags      <= '0;
        end else begin
            if (w_st1_en) begin
                r_st1_v <= bus.s_valid;
                if (bus.s_valid) begin
                    r_st1_sign   <= bus.s_sign;
                    r_st1_exp    <= w_n_exp;
                    r_st1_frac   <= w_n_frac;
                    r_st1_guard  <= w_n_guard;
                    r_st1_sticky <= w_n_sticky;
                    r_st1_class  <= bus.s_class;
                end
            end
            if (w_st2_en) begin
                r_st2_v <= r_st1_v;
                if (r_st1_v) begin
                    r_z     <= w_z;
                    r_flags <= w_flags;
                end
            end
        end
    end

    assign bus.m_valid = r_st2_v;
    assign bus.z       = r_z;
    assign bus.flags   = r_flags;

endmodule

// File: tb/tb_fmul_post_norm.sv
// Directed self-checking bench for fmul_post_norm.
module tb_fmul_post_norm;
    import fmul_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fmul_post_norm_if #(.EXP_W(10)) bus ();

    fmul_post_norm #(
        .EXP_W     (10),
        .NAN_CANON (32'h7FC0_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

`ifdef FMUL_DENORM_EN
    localparam logic [31:0] UF_Z  = 32'h0040_0000;
    localparam logic [2:0]  UF_F  = 3'b000;
    localparam logic [31:0] UF2_Z = 32'h8030_0000;
    localparam logic [2:0]  UF2_F = 3'b011;
`else
    localparam logic [31:0] UF_Z  = 32'h0000_0000;
    localparam logic [2:0]  UF_F  = 3'b011;
    localparam logic [31:0] UF2_Z = 32'h8000_0000;
    localparam logic [2:0]  UF2_F = 3'b011;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one product on an idle pipeline and check latency, result and single emission.
    task automatic send_one(input string tag, input logic sign, input logic signed [9:0] e,
                            input logic [47:0] mant, input fmul_class_e cls,
                            input logic [31:0] exp_z, input logic [2:0] exp_f);
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_sign  = sign;
        bus.s_exp   = e;
        bus.s_mant  = mant;
        bus.s_class = cls;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        check_eq({tag, "_early"}, 64'(bus.m_valid), 64'd0);
        @(posedge clk); #1;
        check_eq({tag, "_valid"}, 64'(bus.m_valid), 64'd1);
        check_eq({tag, "_z"}, 64'(bus.z), 64'(exp_z));
        check_eq({tag, "_flags"}, 64'(bus.flags), 64'(exp_f));
        @(posedge clk); #1;
        check_eq({tag, "_once"}, 64'(bus.m_valid), 64'd0);
    endtask

    task automatic run_backpressure();
        int  sent = 0;
        int  got = 0;
        int  cyc = 0;
        int  stall_left = 0;
        bit  acc;
        bit  saw_sready_low = 0;
        bit  held = 0;
        logic [34:0] held_res = '0;
        while (got < 8 && cyc < 200) begin
            @(posedge clk); #1;
            bus.m_ready = (stall_left == 0);
            if (sent < 8) begin
                bus.s_valid = 1'b1;
                bus.s_sign  = 1'b0;
                bus.s_exp   = 10'sd127;
                bus.s_mant  = 48'h4000_0000_0000 | (48'(sent) << 23);
                bus.s_class = ClsNormal;
            end else begin
                bus.s_valid = 1'b0;
            end
            @(negedge clk);
            if (!bus.s_ready) saw_sready_low = 1;
            acc = bus.s_valid && bus.s_ready;
            if (held) begin
                check_eq("bp_hold_valid", 64'(bus.m_valid), 64'd1);
                check_eq("bp_hold_res", 64'({bus.flags, bus.z}), 64'(held_res));
            end
            held     = bus.m_valid && !bus.m_ready;
            held_res = {bus.flags, bus.z};
            if (stall_left > 0) stall_left--;
            if (bus.m_valid && bus.m_ready) begin
                check_eq("bp_res", 64'({bus.flags, bus.z}), 64'({3'b000, 32'(32'h3F80_0000 + got)}));
                got++;
                if (got == 2) stall_left = 5;
            end
            if (acc) sent++;
            cyc++;
        end
        check_eq("bp_count", 64'(got), 64'd8);
        check_eq("bp_sready_drop", 64'(saw_sready_low), 64'd1);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("bp_drained", 64'(bus.m_valid), 64'd0);
    endtask

    task automatic run_reset_midstream();
        bit stale = 0;
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_sign  = 1'b0;
        bus.s_exp   = 10'sd127;
        bus.s_mant  = 48'h4000_0000_0000;
        bus.s_class = ClsNormal;
        @(posedge clk); #1;
        bus.s_mant  = 48'h4000_0080_0000;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        check_eq("rst_inflight", 64'(bus.m_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_async_valid", 64'(bus.m_valid), 64'd0);
        check_eq("rst_async_z", 64'(bus.z), 64'd0);
        check_eq("rst_async_flags", 64'(bus.flags), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        check_eq("rst_sready", 64'(bus.s_ready), 64'd1);
        repeat (5) begin
            @(negedge clk);
            if (bus.m_valid) stale = 1;
        end
        check_eq("rst_no_stale", 64'(stale), 64'd0);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_sign  = 1'b0;
        bus.s_exp   = '0;
        bus.s_mant  = '0;
        bus.s_class = ClsNormal;
        bus.m_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_valid", 64'(bus.m_valid), 64'd0);
        check_eq("reset_z", 64'(bus.z), 64'd0);
        check_eq("reset_flags", 64'(bus.flags), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("reset_sready", 64'(bus.s_ready), 64'd1);

        send_one("mul_1p5", 1'b0, 10'sd127, 48'h9000_0000_0000, ClsNormal, 32'h4010_0000, 3'b000);
        send_one("tie_down", 1'b0, 10'sd127, 48'h4000_0040_0000, ClsNormal, 32'h3F80_0000, 3'b001);
        send_one("tie_up", 1'b0, 10'sd127, 48'h4000_00C0_0000, ClsNormal, 32'h3F80_0002, 3'b001);
        send_one("rnd_carry", 1'b0, 10'sd127, 48'h7FFF_FFC0_0000, ClsNormal, 32'h4000_0000, 3'b001);
        send_one("neg_one", 1'b1, 10'sd127, 48'h4000_0000_0000, ClsNormal, 32'hBF80_0000, 3'b000);
        send_one("ovf", 1'b0, 10'sd254, 48'h8000_0000_0000, ClsNormal, 32'h7F80_0000, 3'b101);
        send_one("ovf_rnd", 1'b0, 10'sd254, 48'h7FFF_FFC0_0000, ClsNormal, 32'h7F80_0000, 3'b101);
        send_one("nan", 1'b1, 10'sd254, 48'h8000_0000_0000, ClsNan, 32'h7FC0_0000, 3'b000);
        send_one("zero", 1'b1, 10'sd5, 48'h4000_0000_0001, ClsZero, 32'h8000_0000, 3'b000);
        send_one("inf", 1'b1, 10'sd5, 48'h4000_0000_0001, ClsInf, 32'hFF80_0000, 3'b000);
        send_one("uf_exact", 1'b0, 10'sd0, 48'h4000_0000_0000, ClsNormal, UF_Z, UF_F);
        send_one("uf_sticky", 1'b1, -10'sd1, 48'h6000_0000_0001, ClsNormal, UF2_Z, UF2_F);
        send_one("uf_deep", 1'b0, -10'sd100, 48'h4000_0000_0000, ClsNormal, 32'h0000_0000, 3'b011);

        run_backpressure();
        run_reset_midstream();
        send_one("after_rst", 1'b0, 10'sd128, 48'h4000_0000_0000, ClsNormal, 32'h4000_0000, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fmul_post_norm.md
FMUL_POST_NORM -- requirements
Module: fmul_post_norm

Interface
REQ-001 SHALL have parameter EXP_W, default 10, signed width of the pre-normalisation biased exponent (ea+eb-127).
REQ-002 SHALL have parameter NAN_CANON, default 32'h7FC00000, the canonical quiet NaN that is emitted for every NaN result.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 s_valid  in  1  upstream product valid.
REQ-006 s_ready  out  1  stage can accept a product.
REQ-007 s_sign  in  1  product sign (sa^sb).
REQ-008 s_exp  in  EXP_W  signed biased exponent sum.
REQ-009 s_mant  in  48  raw 24x24 significand product.
REQ-010 s_class  in  2  operand class: 00 normal, 01 zero, 10 inf, 11 NaN.
REQ-011 m_valid  out  1  result valid.
REQ-012 m_ready  in  1  downstream accepts the result.
REQ-013 z  out  32  IEEE-754 single-precision result.
REQ-014 flags  out  3  {overflow, underflow, inexact} for z.

Function
REQ-015 SHALL be a 2-stage pipeline: stage 1 normalises, stage 2 rounds and packs; latency is exactly 2 cycles from the s_valid&&s_ready edge to m_valid when unstalled.
REQ-016 Throughput SHALL be one result per cycle; s_ready = !(st1_v && st2_v && !m_ready).
REQ-017 While m_valid && !m_ready, z, flags and m_valid SHALL hold stable; no result is ever dropped or duplicated.
REQ-018 Stage 1: if s_mant[47]=1, shift right 1 and exp+1; fraction = 23 bits below the leading 1; guard = next bit; sticky = OR of all remaining bits.
REQ-019 Stage 2: round-to-nearest-even; round-up when guard && (sticky || lsb); a mantissa carry-out SHALL renormalise and increment exp.
REQ-020 Final exp >= 255 SHALL produce ±inf (exp 8'hFF, frac 0) with overflow=1 and inexact=1.
REQ-021 s_class zero -> ±0; inf -> ±inf; NaN -> NAN_CANON; all three with flags=0 and no rounding.
REQ-022 inexact SHALL be 1 iff guard||sticky was nonzero, or overflow occurred.
REQ-023 Simultaneous accept and emit in the same cycle SHALL be lossless.

Reset
REQ-024 rst low SHALL immediately clear both stage valids, m_valid=0, z=0, flags=0; s_ready=1 from the first edge after release.
REQ-025 Reset asserted mid-operation SHALL discard in-flight results; nothing is emitted after release until new input.

Configuration
REQ-026 With FMUL_DENORM_EN defined, final exp <= 0 SHALL right-shift the significand by (1-exp) into a subnormal before rounding (sticky retained); underflow = tiny && inexact.
REQ-027 Without FMUL_DENORM_EN, final exp <= 0 SHALL flush to ±0 with underflow=1 and inexact=1.

Structure
REQ-028 Package fmul_pkg SHALL hold the class encoding enum, BIAS=127, EXP_MAX=255, FRAC_W=23 and the flag bit positions.
REQ-029 Rounding logic SHALL live in a combinational sub-module fmul_round (frac, guard, sticky, lsb -> rounded frac, carry).

Verification
REQ-030 1.5*1.5: s_exp=127, s_mant=48'h9000_0000_0000, class 00 -> z=32'h40100000, flags=000, exactly 2 cycles later.
REQ-031 Tie-to-even: s_exp=127, mant 48'h4000_0040_0000 -> 32'h3F800000, inexact=1; mant 48'h4000_00C0_0000 -> 32'h3F800002, inexact=1.
REQ-032 Overflow: s_exp=254, mant 48'h8000_0000_0000 -> 32'h7F800000, flags=101; class NaN -> 32'h7FC00000, flags=000.
REQ-033 Underflow: s_exp=0, mant 48'h4000_0000_0000 -> with FMUL_DENORM_EN 32'h00400000, flags=000; without it 32'h00000000, flags=011.
REQ-034 Back-pressure: stream 8 back-to-back products, hold m_ready=0 for 5 cycles mid-stream -> s_ready drops; all 8 results emerge in order and unaltered.
REQ-035 Reset mid-stream: assert rst with 2 results in flight -> m_valid=0 asynchronously; no stale result appears after release.
